// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm ringer: fires on the alarm-time match, beeps, snoozes, times out.
// Outputs are decoded from registered state only, so reset clears them without a clock edge.
module alarm_ringer #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] cur_time,
  input  logic [19:0] alarm_time,
  input  logic        alarm_en,
  input  logic        sec_tick,
  input  logic        stop_btn,
  input  logic        snooze_btn,
  output logic        ringing,
  output logic        snoozing,
  output logic        buzzer,
  output logic [1:0]  snooze_left
);

  localparam int RW = $clog2(RING_TIMEOUT_S + 1);
  localparam int SW = $clog2(SNOOZE_S + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RINGING = 2'd1;
  localparam logic [1:0] SNOOZE  = 2'd2;

  localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_S - 1);
  localparam logic [RW-1:0] RING_SAT  = RW'(RING_TIMEOUT_S);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_S);
  localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

  logic [1:0]    state;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;
  logic [1:0]    left_q;
  logic          buzz_phase;
  logic          match_q;
  logic          match;
  logic          trigger;

  assign match   = alarm_en && (cur_time == alarm_time);
  assign trigger = match && !match_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      left_q     <= 2'd0;
      buzz_phase <= 1'b0;
      // Starts high so a match present at reset release is not an edge.
      match_q    <= 1'b1;
    end else begin
      match_q <= match;
      if (!alarm_en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (trigger) begin
              state      <= RINGING;
              left_q     <= SNZ_MAX;
              ring_cnt   <= '0;
              buzz_phase <= 1'b1;
            end
          end
          RINGING: begin
            if (stop_btn) begin
              state <= IDLE;
            end else if (snooze_btn && left_q != 2'd0) begin
              state   <= SNOOZE;
              left_q  <= left_q - 2'd1;
              snz_cnt <= SNZ_LOAD;
            end else if (sec_tick) begin
              buzz_phase <= ~buzz_phase;
              if (ring_cnt >= RING_LAST) begin
                state    <= IDLE;
                ring_cnt <= RING_SAT;
              end else begin
                ring_cnt <= ring_cnt + RW'(1);
              end
            end
          end
          SNOOZE: begin
            if (stop_btn) begin
              state <= IDLE;
            end else if (sec_tick) begin
              if (snz_cnt <= SW'(1)) begin
                state      <= RINGING;
                snz_cnt    <= '0;
                ring_cnt   <= '0;
                buzz_phase <= 1'b1;
              end else begin
                snz_cnt <= snz_cnt - SW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign ringing     = (state == RINGING);
  assign snoozing    = (state == SNOOZE);
  assign buzzer      = ringing && buzz_phase;
  assign snooze_left = left_q;

endmodule

// File: doc/alarm_ringer.md
# alarm_ringer

Alarm ringer: the consumer of the alarm time produced by the alarm-time editor. Each cycle it compares the running BCD clock time with the stored alarm time. On a match it drives a beeping buzzer until the user stops it, snoozes it, or it times out. It sits between the timekeeping counter, the alarm-time register, and the buzzer/LED outputs of the alarm clock top level.

## Interface
- RING_TIMEOUT_S, default 60: number of seconds the alarm rings unattended before it silences itself.
- SNOOZE_S, default 300: snooze duration, in seconds.
- MAX_SNOOZE, default 3: number of snoozes allowed per alarm event.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- cur_time  input  20  current time, packed BCD {h_tens[1:0], h_units[3:0], m_tens[2:0], m_units[3:0], s_tens[2:0], s_units[3:0]}.
- alarm_time  input  20  alarm time, same packing; seconds field is always 0.
- alarm_en  input  1  alarm armed (level).
- sec_tick  input  1  one-cycle pulse, once per second, coincident with the cur_time update.
- stop_btn  input  1  stop request, single-cycle edge.
- snooze_btn  input  1  snooze request, single-cycle edge.
- ringing  output  1  high in the RINGING state.
- snoozing  output  1  high in the SNOOZE state.
- buzzer  output  1  beep drive: 1 s on, 1 s off while ringing.
- snooze_left  output  2  snoozes remaining in the current event.

## Operation
- match = alarm_en && (cur_time == alarm_time), full 20-bit compare.
- match_q is the registered copy of match; it resets to 1 so no alarm fires spuriously out of reset.
- trigger = match && !match_q, i.e. the rising edge of match. It fires once per day per alarm time.
- States: IDLE, RINGING, SNOOZE. All transitions are registered.
- IDLE:
  - trigger -> RINGING.
  - Load snooze_left = MAX_SNOOZE, ring counter = 0, buzz phase = 1.
- RINGING:
  - stop_btn -> IDLE.
  - snooze_btn with snooze_left != 0 -> SNOOZE. Decrement snooze_left; load snooze counter = SNOOZE_S.
  - snooze_btn with snooze_left == 0 is ignored; the alarm keeps ringing.
  - sec_tick: ring counter +1 and the buzz phase toggles. When the counter reaches RING_TIMEOUT_S -> IDLE.
- SNOOZE:
  - sec_tick decrements the snooze counter.
  - The tick that takes the counter from 1 to 0 -> RINGING, with ring counter = 0 and buzz phase = 1.
  - stop_btn -> IDLE. snooze_btn is ignored.
- alarm_en low forces IDLE from any state and has the highest priority.
- stop_btn and snooze_btn in the same cycle: stop wins.
- stop_btn or snooze_btn in the same cycle as the timeout tick: the button wins.
- trigger while in RINGING or SNOOZE is ignored; the current event continues.
- Counter widths are $clog2(param+1). Counters saturate and never wrap.
- snooze_left is 2 bits wide, so MAX_SNOOZE is at most 3.
- buzzer = ringing && buzz_phase.
- Outputs are registered or derived from state only; none depend combinationally on inputs.

## Timing
- Reset (asynchronous) values: state IDLE, ringing 0, snoozing 0, buzzer 0, snooze_left 0, all counters 0, match_q 1.
- Reset asserted mid-ring or mid-snooze: outputs drop to 0 immediately, without waiting for a clock edge.
- Latency:
  - cur_time becomes equal to alarm_time at edge N; ringing and buzzer go high after edge N+1.
  - Button at edge N: ringing or snoozing changes after edge N+1.
- Buzzer pattern: on for the first second (until the first sec_tick), then toggles on every sec_tick.
- Timeout: exactly RING_TIMEOUT_S sec_ticks after RINGING is entered, ringing falls on the clock edge following the final tick.
- Snooze: exactly SNOOZE_S sec_ticks after snooze_btn, the block re-enters RINGING.
- sec_tick can be high on every cycle, for fast simulation; behaviour is then identical per tick.

## Test plan
- Alarm match:
  - Stimulus: alarm_time = 07:30:00, alarm_en = 1, cur_time stepped from 07:29:59 to 07:30:00.
  - Response: ringing = 1 one cycle later; buzzer = 1, 0, 1 on successive sec_ticks; ringing = 0 after the 60th tick.
- Snooze:
  - Stimulus: snooze_btn while ringing.
  - Response: snoozing = 1 and snooze_left = 2. After 300 sec_ticks, ringing = 1 again with buzzer = 1.
  - Repeat 3 snoozes: the 4th snooze_btn is ignored and ringing stays 1.
- Stop/snooze priority:
  - Stimulus: stop_btn and snooze_btn asserted in the same cycle while ringing.
  - Response: IDLE, ringing = 0, snoozing = 0. No re-ring while cur_time holds 07:30:00 for the rest of the second.
- Disable and reset:
  - alarm_en dropped during SNOOZE -> IDLE the next cycle.
  - reset asserted asynchronously mid-ring -> all outputs 0 immediately.
  - reset released while cur_time == alarm_time -> no ring.
- Non-match:
  - Stimulus: alarm_en = 0 at the match time, or cur_time = 07:30:01.
  - Response: no ring. Also 23:59:59 -> 00:00:00 with alarm_time = 00:00:00 -> rings.
